// File: rtl/rggen_irq_pkg.sv
// Shared constants for the interrupt capture slice.
// The EDGE/LEVEL encoding matches what the register generator emits for EDGE_MODE bits.
package rggen_irq_pkg;

    localparam logic IRQ_LEVEL = 1'b0;
    localparam logic IRQ_EDGE  = 1'b1;

endpackage

// File: rtl/rggen_irq_sync.sv
// WIDTH-wide, SYNC_STAGES-deep reset-to-0 synchroniser.
// With SYNC_STAGES = 0 the input passes straight through.
module rggen_irq_sync #(
    parameter int WIDTH       = 1,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] i_d,
    output logic [WIDTH-1:0] o_q
);

    generate
        if (SYNC_STAGES == 0) begin : g_bypass
            logic w_unused_ok;
            assign w_unused_ok = &{1'b0, clk, rst_n};
            assign o_q = i_d;
        end else begin : g_sync
            logic [WIDTH-1:0] r_stages [SYNC_STAGES];

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    for (int s = 0; s < SYNC_STAGES; s++) begin
                        r_stages[s] <= '0;
                    end
                end else begin
                    r_stages[0] <= i_d;
                    for (int s = 1; s < SYNC_STAGES; s++) begin
                        r_stages[s] <= r_stages[s-1];
                    end
                end
            end

            assign o_q = r_stages[SYNC_STAGES-1];
        end
    endgenerate

endmodule

// File: rtl/rggen_irq_status_capture.sv
// Per-source interrupt capture: polarity normalisation, synchronisation, level/edge
// detection, sticky W1C/W1S status and sticky lost-edge overflow.
module rggen_irq_status_capture
    import rggen_irq_pkg::*;
#(
    parameter int               WIDTH       = 1,
    parameter int               SYNC_STAGES = 2,
    parameter logic [WIDTH-1:0] EDGE_MODE   = '0,
    parameter logic [WIDTH-1:0] ACTIVE_LOW  = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] i_irq_src,
    input  logic             i_clear_valid,
    input  logic [WIDTH-1:0] i_clear_mask,
    input  logic             i_set_valid,
    input  logic [WIDTH-1:0] i_set_mask,
    output logic [WIDTH-1:0] o_isr,
    output logic [WIDTH-1:0] o_ovf,
    output logic [WIDTH-1:0] o_event
);

    logic [WIDTH-1:0] w_norm;
    logic [WIDTH-1:0] w_sync;
    logic [WIDTH-1:0] w_event;
    logic [WIDTH-1:0] w_clr;
    logic [WIDTH-1:0] w_set;
    logic [WIDTH-1:0] w_isrNext;
    logic [WIDTH-1:0] w_ovfNext;
    logic [WIDTH-1:0] r_prev;
    logic [WIDTH-1:0] r_isr;
    logic [WIDTH-1:0] r_ovf;

    // Inverting before the synchroniser keeps the inactive level at 0 through reset.
    assign w_norm = i_irq_src ^ ACTIVE_LOW;

    rggen_irq_sync #(
        .WIDTH       (WIDTH),
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .i_d   (w_norm),
        .o_q   (w_sync)
    );

    assign w_clr = {WIDTH{i_clear_valid}} & i_clear_mask;
    assign w_set = {WIDTH{i_set_valid}} & i_set_mask;

    // Event and set win over clear; an edge coinciding with its clear re-pends without overflow.
    always_comb begin
        w_event   = '0;
        w_ovfNext = '0;
        for (int i = 0; i < WIDTH; i++) begin
            if (EDGE_MODE[i] == IRQ_EDGE) begin
                w_event[i]   = w_sync[i] & ~r_prev[i];
                w_ovfNext[i] = (r_ovf[i] & ~w_clr[i]) | (w_event[i] & r_isr[i] & ~w_clr[i]);
            end else begin
                w_event[i]   = w_sync[i];
                w_ovfNext[i] = 1'b0;
            end
        end
        w_isrNext = (r_isr & ~w_clr) | w_event | w_set;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_prev <= '0;
            r_isr  <= '0;
            r_ovf  <= '0;
        end else begin
            r_prev <= w_sync;
            r_isr  <= w_isrNext;
            r_ovf  <= w_ovfNext;
        end
    end

    assign o_isr   = r_isr;
    assign o_ovf   = r_ovf;
    assign o_event = w_event;

endmodule
